// File: rtl/pkt_pkg.sv
// Shared packet definitions for the packet source arbiter: beat field layout,
// packet type constants and the arbiter state encoding.
package pkt_pkg;

   localparam int PKT_W       = 13;
   localparam int DST_LSB     = 11;
   localparam int DST_W       = 2;
   localparam int TYPE_LSB    = 9;
   localparam int TYPE_W      = 2;
   localparam int PAYLOAD_LSB = 1;
   localparam int PAYLOAD_W   = 8;
   localparam int EOP_BIT     = 0;

   localparam logic [TYPE_W-1:0] PKT_T_URGENT = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_e;

   function automatic logic is_urgent(input logic [PKT_W-1:0] beat);
      return (beat[TYPE_LSB +: TYPE_W] == PKT_T_URGENT);
   endfunction

endpackage

// File: rtl/pkt_src_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo N; returns one-hot grant, its index and an any-request flag.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   // Walk the request vector starting at the pointer; the first hit wins.
   always_comb begin
      logic [IW-1:0] pos_v;
      logic          hit_v;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      pos_v = '0;
      hit_v = 1'b0;
      for (int k = 0; k < N; k++) begin
         pos_v        = IW'((int'(ptr_i) + k) % N);
         hit_v        = !any_o && req_i[pos_v];
         gnt_o[pos_v] = gnt_o[pos_v] | hit_v;
         idx_o        = hit_v ? pos_v : idx_o;
         any_o        = any_o | hit_v;
      end
   end

endmodule

// File: rtl/pkt_src_arbiter.sv
// Round-robin packet arbiter with a single registered output stage; the grant
// is held until end-of-packet or MAX_BEATS. Optional feature: PKT_ARB_URGENT_EN.
module pkt_src_arbiter
   import pkt_pkg::*;
#(
   parameter int NUM_SRC   = 4,
   parameter int MAX_BEATS = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_SRC*PKT_W-1:0] src_pkt,
   input  logic [NUM_SRC-1:0]       src_valid,
   output logic [NUM_SRC-1:0]       src_ready,
   output logic [PKT_W-1:0]         pkt_out,
   output logic                     pkt_valid,
   input  logic                     pkt_ready,
   output logic [NUM_SRC-1:0]       grant,
   output logic                     busy,
   output logic                     trunc_err
);

   localparam int         IW    = $clog2(NUM_SRC);
   localparam logic [7:0] MAX_B = 8'(MAX_BEATS);

   arb_state_e         state_q, state_d;
   logic [NUM_SRC-1:0] grant_q, grant_d;
   logic [IW-1:0]      gidx_q, gidx_d;
   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [PKT_W-1:0]   pkt_out_q, pkt_out_d;
   logic               pkt_valid_q, pkt_valid_d;
   logic               trunc_q, trunc_d;

   logic [NUM_SRC-1:0] pick_gnt_s;
   logic [IW-1:0]      pick_idx_s;
   logic               pick_any_s;

`ifdef PKT_ARB_URGENT_EN
   logic [NUM_SRC-1:0] urg_req_s, urg_gnt_s, all_gnt_s;
   logic [IW-1:0]      urg_idx_s, all_idx_s;
   logic               urg_any_s, all_any_s;

   // Urgent requesters are those whose presented beat carries the urgent type.
   always_comb begin
      urg_req_s = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         urg_req_s[i] = src_valid[i] && is_urgent(src_pkt[i*PKT_W +: PKT_W]);
      end
   end

   rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick_urg (
      .req_i(urg_req_s), .ptr_i(rr_ptr_q),
      .gnt_o(urg_gnt_s), .idx_o(urg_idx_s), .any_o(urg_any_s)
   );
   rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick_all (
      .req_i(src_valid), .ptr_i(rr_ptr_q),
      .gnt_o(all_gnt_s), .idx_o(all_idx_s), .any_o(all_any_s)
   );

   assign pick_gnt_s = urg_any_s ? urg_gnt_s : all_gnt_s;
   assign pick_idx_s = urg_any_s ? urg_idx_s : all_idx_s;
   assign pick_any_s = all_any_s;
`else
   rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick_all (
      .req_i(src_valid), .ptr_i(rr_ptr_q),
      .gnt_o(pick_gnt_s), .idx_o(pick_idx_s), .any_o(pick_any_s)
   );
`endif

   logic [PKT_W-1:0] sel_beat_s;
   logic [7:0]       beat_num_s;
   logic             out_free_s, load_s, at_max_s, trunc_hit_s, release_s;
   logic [IW-1:0]    next_ptr_s;

   assign sel_beat_s  = src_pkt[int'(gidx_q)*PKT_W +: PKT_W];
   assign out_free_s  = !pkt_valid_q || pkt_ready;
   assign load_s      = (state_q == XFER) && src_valid[gidx_q] && out_free_s;
   assign beat_num_s  = cnt_q + 8'd1;
   assign at_max_s    = (beat_num_s == MAX_B);
   // A beat reaching MAX_BEATS without eop is cut short and the grant released.
   assign trunc_hit_s = load_s && at_max_s && !sel_beat_s[EOP_BIT];
   assign release_s   = load_s && (sel_beat_s[EOP_BIT] || at_max_s);
   assign next_ptr_s  = (gidx_q == IW'(NUM_SRC - 1)) ? IW'(0) : gidx_q + IW'(1);

   // Only the granted source may see ready, and only when the output slot frees.
   always_comb begin
      src_ready = '0;
      if (state_q == XFER) begin
         src_ready[gidx_q] = out_free_s;
      end else begin
         src_ready = '0;
      end
   end

   // Arbitration FSM next state, grant, beat counter and round-robin pointer.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      gidx_d   = gidx_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_any_s) begin
               state_d = XFER;
               grant_d = pick_gnt_s;
               gidx_d  = pick_idx_s;
               cnt_d   = 8'd0;
            end else begin
               state_d = IDLE;
            end
         end
         XFER: begin
            if (release_s) begin
               state_d  = IDLE;
               grant_d  = '0;
               rr_ptr_d = next_ptr_s;
               cnt_d    = beat_num_s;
            end else if (load_s) begin
               cnt_d = beat_num_s;
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Output register: a load replaces the beat; an accept without load drains it.
   always_comb begin
      pkt_out_d   = pkt_out_q;
      pkt_valid_d = pkt_valid_q;
      trunc_d     = trunc_q | trunc_hit_s;
      if (load_s) begin
         pkt_out_d          = sel_beat_s;
         pkt_out_d[EOP_BIT] = sel_beat_s[EOP_BIT] | trunc_hit_s;
         pkt_valid_d        = 1'b1;
      end else if (pkt_ready) begin
         pkt_valid_d = 1'b0;
      end else begin
         pkt_valid_d = pkt_valid_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         gidx_q      <= '0;
         rr_ptr_q    <= '0;
         cnt_q       <= 8'd0;
         pkt_out_q   <= '0;
         pkt_valid_q <= 1'b0;
         trunc_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         gidx_q      <= gidx_d;
         rr_ptr_q    <= rr_ptr_d;
         cnt_q       <= cnt_d;
         pkt_out_q   <= pkt_out_d;
         pkt_valid_q <= pkt_valid_d;
         trunc_q     <= trunc_d;
      end
   end

   assign pkt_out   = pkt_out_q;
   assign pkt_valid = pkt_valid_q;
   assign grant     = grant_q;
   assign busy      = (state_q == XFER);
   assign trunc_err = trunc_q;

endmodule
